// File: rtl/etc_link_pkg.sv
// Shared definitions for the ETC speed link (TX framer and RX receiver).
// Optional feature macro: SPEED_CHECKSUM_EN adds a trailing checksum byte to each frame.
package etc_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Byte-level receive states: start bit, data bits, stop bit.
  typedef enum logic [1:0] {
    BtIdle,
    BtStart,
    BtData,
    BtStop
  } byte_state_e;

  // Frame assembler states; the checksum state only exists when the checksum is enabled.
  typedef enum logic [1:0] {
    FrWaitSync,
    FrGetHi,
    FrGetLo
`ifdef SPEED_CHECKSUM_EN
    , FrGetCk
`endif
  } frame_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 UART byte receiver: input synchroniser, free-running sample-tick
// divider and start/data/stop FSM. Delivers one byte per good frame.
module uart_rx_core
  import etc_link_pkg::*;
#(
  parameter int unsigned BAUD_DVSR = 271,
  parameter int unsigned SAMPLE    = 16,
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic [DATA_SIZE-1:0] byte_o,
  output logic                 byte_valid_o,
  output logic                 byte_err_o,
  output logic                 busy_o
);

  localparam int unsigned DivW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam int unsigned TcW  = $clog2(SAMPLE);
  localparam int unsigned BcW  = $clog2(DATA_SIZE + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(BAUD_DVSR - 1);
  localparam logic [TcW-1:0]  TcMid   = TcW'(SAMPLE / 2 - 1);
  localparam logic [TcW-1:0]  TcLast  = TcW'(SAMPLE - 1);
  localparam logic [BcW-1:0]  BcLast  = BcW'(DATA_SIZE - 1);

  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [DivW-1:0]      div_q;
  byte_state_e          state_q, state_d;
  logic [TcW-1:0]       tcnt_q, tcnt_d;
  logic [BcW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;

  logic rx_s, fall, tick;

  assign rx_s   = sync_q[1];
  assign fall   = prev_q & ~rx_s;
  assign tick   = (div_q == DivLast);
  assign byte_o = shift_q;
  assign busy_o = (state_q != BtIdle);

  // Two-stage synchroniser plus edge-history flop; idle line is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  // Free-running sample-tick divider, never realigned to the line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Byte FSM state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BtIdle;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

  // Byte FSM next state; a stop bit held low only re-arms via a fresh falling edge.
  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    byte_err_o   = 1'b0;
    case (state_q)
      BtIdle: begin
        if (fall) begin
          state_d = BtStart;
          tcnt_d  = '0;
        end
      end
      BtStart: begin
        if (tick) begin
          if (tcnt_q == TcMid) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rx_s ? BtIdle : BtData;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      BtData: begin
        if (tick) begin
          if (tcnt_q == TcLast) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[DATA_SIZE-1:1]};
            if (bcnt_q == BcLast) begin
              state_d = BtStop;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      BtStop: begin
        if (tick) begin
          if (tcnt_q == TcLast) begin
            state_d      = BtIdle;
            byte_valid_o = rx_s;
            byte_err_o   = ~rx_s;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = BtIdle;
    endcase
  end

endmodule

// File: rtl/uart_speed_receiver.sv
// ETC speed link receiver: UART byte core plus frame assembler for {0xA5, HI, LO}.
// Optional feature macro: SPEED_CHECKSUM_EN expects {0xA5, HI, LO, CK}, CK = 0xA5^HI^LO.
module uart_speed_receiver
  import etc_link_pkg::*;
#(
  parameter int unsigned SYS_FREQ    = 50000000,
  parameter int unsigned BAUD_RATE   = 11500,
  parameter int unsigned SAMPLE      = 16,
  parameter int unsigned BAUD_DVSR   = SYS_FREQ / (SAMPLE * BAUD_RATE),
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned WIDTH_SPEED = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   serial_data_in,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic                   speed_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  logic [DATA_SIZE-1:0] rx_byte;
  logic                 rx_valid, rx_err;

  uart_rx_core #(
    .BAUD_DVSR (BAUD_DVSR),
    .SAMPLE    (SAMPLE),
    .DATA_SIZE (DATA_SIZE)
  ) u_rx_core (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .rx_i         (serial_data_in),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .byte_err_o   (rx_err),
    .busy_o       (rx_busy)
  );

  frame_state_e           frame_q, frame_d;
  logic [WIDTH_SPEED-1:0] speed_q, speed_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
`ifdef SPEED_CHECKSUM_EN
  logic [7:0]             hi_q, hi_d;
  logic [7:0]             lo_q, lo_d;
`else
  logic [WIDTH_SPEED-9:0] hi_q, hi_d;
`endif

  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign frame_err   = err_q;

  // Frame assembler registers; outputs are registered so pulses land one clk after the byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= FrWaitSync;
      speed_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= '0;
`ifdef SPEED_CHECKSUM_EN
      lo_q    <= '0;
`endif
    end else begin
      frame_q <= frame_d;
      speed_q <= speed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hi_q    <= hi_d;
`ifdef SPEED_CHECKSUM_EN
      lo_q    <= lo_d;
`endif
    end
  end

  // Frame assembler next state; a repeated sync byte in place of HI restarts the frame.
  always_comb begin
    frame_d = frame_q;
    speed_d = speed_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    hi_d    = hi_q;
`ifdef SPEED_CHECKSUM_EN
    lo_d    = lo_q;
`endif
    if (rx_err) begin
      err_d   = 1'b1;
      frame_d = FrWaitSync;
    end else if (rx_valid) begin
      case (frame_q)
        FrWaitSync: begin
          if (rx_byte == SYNC_BYTE) frame_d = FrGetHi;
        end
        FrGetHi: begin
          if (rx_byte == SYNC_BYTE) begin
            frame_d = FrGetHi;
          end else if (rx_byte[7:WIDTH_SPEED-8] != '0) begin
            err_d   = 1'b1;
            frame_d = FrWaitSync;
          end else begin
`ifdef SPEED_CHECKSUM_EN
            hi_d    = rx_byte;
`else
            hi_d    = rx_byte[WIDTH_SPEED-9:0];
`endif
            frame_d = FrGetLo;
          end
        end
        FrGetLo: begin
`ifdef SPEED_CHECKSUM_EN
          lo_d    = rx_byte;
          frame_d = FrGetCk;
`else
          speed_d = {hi_q[WIDTH_SPEED-9:0], rx_byte};
          valid_d = 1'b1;
          frame_d = FrWaitSync;
`endif
        end
`ifdef SPEED_CHECKSUM_EN
        FrGetCk: begin
          if (rx_byte == (SYNC_BYTE ^ hi_q ^ lo_q)) begin
            speed_d = {hi_q[WIDTH_SPEED-9:0], lo_q};
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          frame_d = FrWaitSync;
        end
`endif
        default: frame_d = FrWaitSync;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_speed_receiver.sv
// Scoreboard bench for uart_speed_receiver with a fast baud divider (2 clks per tick).
module tb_uart_speed_receiver;

  localparam int W   = 14;
  localparam int DV  = 2;
  localparam int BIT = 16 * DV;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         serial_data_in;
  logic [W-1:0] speed;
  logic         speed_valid, frame_err, rx_busy;

  uart_speed_receiver #(
    .SYS_FREQ    (320000),
    .BAUD_RATE   (10000),
    .SAMPLE      (16),
    .DATA_SIZE   (8),
    .WIDTH_SPEED (W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .serial_data_in (serial_data_in),
    .speed          (speed),
    .speed_valid    (speed_valid),
    .frame_err      (frame_err),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit           is_err;
    logic [W-1:0] spd;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nerr = 0;

  // Reference model of the protocol: where in the frame we are, and what was captured.
  int m_pos   = 0;
  int m_hi    = 0;
  int m_lo    = 0;
  int m_speed = 0;

`ifdef SPEED_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_err, input int spd);
    exp_t e;
    e.is_err = is_err;
    e.spd    = W'(spd);
    exp_q.push_back(e);
  endtask

  task automatic model(input int b, input bit berr);
    if (berr) begin
      push(1'b1, 0);
      m_pos = 0;
    end else if (m_pos == 0) begin
      if (b == 'hA5) m_pos = 1;
    end else if (m_pos == 1) begin
      if (b == 'hA5) m_pos = 1;
      else if (b >= (1 << (W - 8))) begin
        push(1'b1, 0);
        m_pos = 0;
      end else begin
        m_hi  = b;
        m_pos = 2;
      end
    end else if (m_pos == 2) begin
      m_lo = b;
      if (!CK) begin
        m_speed = m_hi * 256 + m_lo;
        push(1'b0, m_speed);
        m_pos = 0;
      end else begin
        m_pos = 3;
      end
    end else begin
      if (b == ('hA5 ^ m_hi ^ m_lo)) begin
        m_speed = m_hi * 256 + m_lo;
        push(1'b0, m_speed);
      end else begin
        push(1'b1, 0);
      end
      m_pos = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap,
                           input bit chk_busy);
    model(int'(b), !stop_ok);
    serial_data_in = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_data_in = b[i];
      if (chk_busy && i == 0) begin
        @(negedge clk);
        chk("busy_mid_byte", int'(rx_busy), 1);
        repeat (BIT - 1) @(posedge clk);
      end else begin
        repeat (BIT) @(posedge clk);
      end
    end
    serial_data_in = stop_ok;
    repeat (BIT) @(posedge clk);
    serial_data_in = 1'b1;
    repeat (stop_ok ? gap : gap + BIT) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit good_ck);
    logic [7:0] ck;
    ck = 8'hA5 ^ hi ^ lo;
    if (!good_ck) ck = ~ck;
    send_byte(8'hA5, 1'b1, $urandom_range(0, 10), 1'b0);
    send_byte(hi, 1'b1, $urandom_range(0, 10), 1'b0);
    send_byte(lo, 1'b1, $urandom_range(0, 10), 1'b0);
    if (CK) send_byte(ck, 1'b1, $urandom_range(0, 10), 1'b0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (speed_valid && frame_err) chk("valid_err_overlap", 1, 0);
      if (speed_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({speed_valid, frame_err}), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", int'(frame_err), int'(e.is_err));
          if (!e.is_err) chk("pulse_speed", int'(speed), int'(e.spd));
        end
      end
    end
  end

  logic [7:0] hi, lo;
  int         r;

  initial begin
    serial_data_in = 1'b1;
    reset_n        = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_speed", int'(speed), 0);
    chk("rst_valid", int'(speed_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(rx_busy), 0);
    reset_n = 1'b1;
    repeat (BIT) @(posedge clk);

    // Basic frame.
    send_byte(8'hA5, 1'b1, 5, 1'b1);
    send_byte(8'h2A, 1'b1, 5, 1'b0);
    send_byte(8'h5C, 1'b1, 5, 1'b0);
    if (CK) send_byte(8'hD3, 1'b1, 5, 1'b0);
    @(negedge clk);
    chk("t1_speed", int'(speed), 'h2A5C);
    chk("t1_idle_busy", int'(rx_busy), 0);

    // Short low glitch on an idle line must not produce a byte.
    serial_data_in = 1'b0;
    repeat (8) @(posedge clk);
    serial_data_in = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    send_frame(8'h00, 8'h64, 1'b1);
    @(negedge clk);
    chk("t2_speed", int'(speed), 100);

    // Stop-bit error aborts the frame.
    send_byte(8'hA5, 1'b1, 5, 1'b0);
    send_byte(8'h2A, 1'b0, 5, 1'b0);
    send_frame(8'h01, 8'h00, 1'b1);
    @(negedge clk);
    chk("t3_speed", int'(speed), 256);

    // Out-of-range HI byte; the following LO is ignored.
    send_byte(8'hA5, 1'b1, 5, 1'b0);
    send_byte(8'hC0, 1'b1, 5, 1'b0);
    send_byte(8'h11, 1'b1, 5, 1'b0);
    @(negedge clk);
    chk("t4_speed_held", int'(speed), 256);

    // Resync on a repeated sync byte.
    send_byte(8'hA5, 1'b1, 5, 1'b0);
    send_frame(8'h3F, 8'hFF, 1'b1);
    @(negedge clk);
    chk("t5_speed", int'(speed), 'h3FFF);

`ifdef SPEED_CHECKSUM_EN
    send_frame(8'h2A, 8'h5C, 1'b1);
    @(negedge clk);
    chk("t6_ck_good", int'(speed), 'h2A5C);
    send_byte(8'hA5, 1'b1, 5, 1'b0);
    send_byte(8'h2A, 1'b1, 5, 1'b0);
    send_byte(8'h5C, 1'b1, 5, 1'b0);
    send_byte(8'h00, 1'b1, 5, 1'b0);
    @(negedge clk);
    chk("t6_ck_bad_held", int'(speed), 'h2A5C);
`endif

    // Randomised frames, noise and errors.
    for (int f = 0; f < 16; f++) begin
      r = $urandom_range(0, 9);
      hi = 8'($urandom_range(0, (1 << (W - 8)) - 1));
      lo = 8'($urandom_range(0, 255));
      if (r <= 4) begin
        send_frame(hi, lo, 1'b1);
      end else if (r == 5) begin
        hi = 8'($urandom_range(1 << (W - 8), 255));
        if (hi == 8'hA5) hi = 8'hFF;
        send_byte(8'hA5, 1'b1, 3, 1'b0);
        send_byte(hi, 1'b1, 3, 1'b0);
        send_byte(lo, 1'b1, 3, 1'b0);
      end else if (r == 6) begin
        send_byte(8'hA5, 1'b1, 3, 1'b0);
        send_byte(hi, 1'b0, 3, 1'b0);
      end else if (r == 7) begin
        send_byte(lo, 1'b1, 3, 1'b0);
      end else if (r == 8) begin
        send_byte(8'hA5, 1'b1, 3, 1'b0);
        send_frame(hi, lo, 1'b1);
      end else begin
        send_frame(hi, lo, 1'b0);
      end
    end
    @(negedge clk);
    chk("rand_speed", int'(speed), m_speed);

    // Reset in the middle of the LO byte discards the partial frame.
    send_byte(8'hA5, 1'b1, 5, 1'b0);
    send_byte(8'h01, 1'b1, 5, 1'b0);
    if (m_pos == 0) send_byte(8'hA5, 1'b1, 5, 1'b0);
    serial_data_in = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", int'(rx_busy), 1);
    reset_n = 1'b0;
    serial_data_in = 1'b1;
    exp_q.delete();
    m_pos   = 0;
    m_speed = 0;
    @(negedge clk);
    chk("mid_rst_speed", int'(speed), 0);
    chk("mid_rst_valid", int'(speed_valid), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    chk("mid_rst_busy", int'(rx_busy), 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12 * BIT) @(posedge clk);
    chk("post_rst_speed", int'(speed), 0);

    // One more frame after reset to confirm recovery.
    send_frame(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_queue", exp_q.size(), 0);
    @(negedge clk);
    chk("final_speed", int'(speed), 'h1234);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
